// File: rtl/alu_exec_unit.sv
// alu_exec_unit: clocked ALU with valid/ready issue and write-back handshakes.
// Define ALU_MUL_EN to add the iterative shift-add multiply on opcode 10.
module alu_exec_unit #(
  parameter int DATA_W = 32,
  parameter int SEL_W  = 8,
  parameter int IMM_W  = 24
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              OpValid,
  output logic              OpReady,
  input  logic [SEL_W-1:0]  ALU_Sel,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [IMM_W-1:0]  DecoderData,
  output logic              ResValid,
  input  logic              ResReady,
  output logic [DATA_W-1:0] Result,
  output logic              WrEn,
  output logic [7:0]        StatusOut,
  output logic [2:0]        MenagePC
);

  localparam int M    = DATA_W - 1;
  localparam int SH_W = $clog2(DATA_W);

  localparam logic [SEL_W-1:0] OP_NOP   = SEL_W'(0);
  localparam logic [SEL_W-1:0] OP_ADDIM = SEL_W'(1);
  localparam logic [SEL_W-1:0] OP_ADD   = SEL_W'(2);
  localparam logic [SEL_W-1:0] OP_SUB   = SEL_W'(3);
  localparam logic [SEL_W-1:0] OP_AND   = SEL_W'(4);
  localparam logic [SEL_W-1:0] OP_OR    = SEL_W'(5);
  localparam logic [SEL_W-1:0] OP_XOR   = SEL_W'(6);
  localparam logic [SEL_W-1:0] OP_SHL   = SEL_W'(7);
  localparam logic [SEL_W-1:0] OP_SHR   = SEL_W'(8);
  localparam logic [SEL_W-1:0] OP_CMP   = SEL_W'(9);

`ifdef ALU_MUL_EN
  localparam logic [SEL_W-1:0] OP_MUL   = SEL_W'(10);
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, DONE} state_t;
`endif

  state_t            state;
  logic [DATA_W-1:0] res_q;
  logic [4:0]        stat_q;
  logic              wr_q;
  logic              accept;

  logic [DATA_W-1:0] imm_x;
  logic [SH_W-1:0]   sh;
  logic [DATA_W:0]   sum_ab, sum_ai, shl_x, shr_x;
  logic [DATA_W-1:0] dif_ab;

  logic [DATA_W-1:0] c_res;
  logic              c_c, c_v, c_wr, c_upd, c_ill, c_mul;
  logic [4:0]        c_flags;

  generate
    if (IMM_W >= DATA_W) begin : g_imm_trunc
      assign imm_x = DecoderData[DATA_W-1:0];
    end else begin : g_imm_zext
      assign imm_x = {{(DATA_W-IMM_W){1'b0}}, DecoderData};
    end
  endgenerate

  assign sh     = B[SH_W-1:0];
  assign sum_ab = {1'b0, A} + {1'b0, B};
  assign sum_ai = {1'b0, A} + {1'b0, imm_x};
  assign dif_ab = A - B;
  // Extra bit on the far side of each shift captures the last bit shifted out.
  assign shl_x  = {1'b0, A} << sh;
  assign shr_x  = {A, 1'b0} >> sh;

  always_comb begin
    c_res = '0;
    c_c   = 1'b0;
    c_v   = 1'b0;
    c_wr  = 1'b0;
    c_upd = 1'b1;
    c_ill = 1'b0;
    c_mul = 1'b0;
    unique case (ALU_Sel)
      OP_NOP: c_upd = 1'b0;
      OP_ADDIM: begin
        c_res = sum_ai[M:0];
        c_c   = sum_ai[DATA_W];
        c_v   = ~(A[M] ^ imm_x[M]) & (sum_ai[M] ^ A[M]);
        c_wr  = 1'b1;
      end
      OP_ADD: begin
        c_res = sum_ab[M:0];
        c_c   = sum_ab[DATA_W];
        c_v   = ~(A[M] ^ B[M]) & (sum_ab[M] ^ A[M]);
        c_wr  = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        c_res = dif_ab;
        c_c   = A < B;
        c_v   = (A[M] ^ B[M]) & (dif_ab[M] ^ A[M]);
        c_wr  = (ALU_Sel == OP_SUB);
      end
      OP_AND: begin c_res = A & B; c_wr = 1'b1; end
      OP_OR:  begin c_res = A | B; c_wr = 1'b1; end
      OP_XOR: begin c_res = A ^ B; c_wr = 1'b1; end
      OP_SHL: begin
        c_res = shl_x[M:0];
        c_c   = shl_x[DATA_W];
        c_wr  = 1'b1;
      end
      OP_SHR: begin
        c_res = shr_x[DATA_W:1];
        c_c   = shr_x[0];
        c_wr  = 1'b1;
      end
`ifdef ALU_MUL_EN
      OP_MUL: c_mul = 1'b1;
`endif
      default: c_ill = 1'b1;
    endcase
    c_flags = {c_ill, c_v, c_c, c_res[M], (c_res == '0) & ~c_ill};
  end

`ifdef ALU_MUL_EN
  logic [DATA_W-1:0] acc, mcand, mplier, acc_nxt;
  logic [SH_W-1:0]   cnt;

  assign acc_nxt = acc + (mplier[0] ? mcand : '0);
`endif

  assign ResValid  = (state == DONE);
  assign OpReady   = (state == IDLE) | ((state == DONE) & ResReady);
  assign accept    = OpValid & OpReady;
  assign Result    = res_q;
  assign WrEn      = wr_q & ResValid;
  assign StatusOut = {3'b000, stat_q};
  assign MenagePC  = {2'b00, ResValid & ResReady & ~Rst};

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state  <= IDLE;
      res_q  <= '0;
      stat_q <= '0;
      wr_q   <= 1'b0;
`ifdef ALU_MUL_EN
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
`endif
    end else begin
      if (ResValid && ResReady) state <= IDLE;
      if (accept) begin
        if (c_mul) begin
`ifdef ALU_MUL_EN
          state  <= MUL;
          acc    <= '0;
          mcand  <= A;
          mplier <= B;
          cnt    <= '0;
`endif
        end else begin
          state <= DONE;
          wr_q  <= c_wr;
          if (c_upd) stat_q <= c_flags;
          if (c_wr || c_ill) res_q <= c_res;
        end
      end
`ifdef ALU_MUL_EN
      if (state == MUL) begin
        acc    <= acc_nxt;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (cnt == SH_W'(DATA_W - 1)) begin
          state  <= DONE;
          res_q  <= acc_nxt;
          wr_q   <= 1'b1;
          stat_q <= {3'b000, acc_nxt[M], acc_nxt == '0};
        end
      end
`endif
    end
  end

endmodule
